// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle; signs are applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & in0[WIDTH-1];
    b_neg     = signed_op & in1[WIDTH-1];
    a_mag     = a_neg ? (~in0 + 1'b1) : in0;
    b_mag     = b_neg ? (~in1 + 1'b1) : in1;

    // acc holds {partial product, remaining multiplier bits}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // acc holds {partial remainder, dividend bits shifting into quotient}
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge    = rem_sh >= {1'b0, b_q};
    rem_new   = rem_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
    div_next  = {rem_new, acc_q[WIDTH-2:0], rem_ge};

    prod_fix  = neg_q  ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          b_d      = b_mag;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          dz_d     = op[1] && (in1 == '0);
          cnt_d    = dz_d ? '0 : CW'(WIDTH);
          state_d  = dz_d ? FIX : CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (dz_q) begin
            div_zero_d = 1'b1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32: directed vectors plus random ops against
// a 64-bit arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic         cancel = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .in0(in0), .in1(in1),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    longint unsigned ua, ub, uq, urm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    r = '0;
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = ua * ub;
      2'b10: begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      default: begin uq = ua / ub; urm = ua % ub; r = {urm[31:0], uq[31:0]}; end
    endcase
    return r;
  endfunction

  // Drives one start pulse and waits (bounded) for done; lat = edges from accept (accept = 1).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cyc, output logic dz);
    @(negedge clk);
    start = 1'b1; op = o; in0 = a; in1 = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cyc = 0; dz = 1'b0;
    while (lat < 200 && !done) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (done) dz = div_zero;
    else lat = -1;
  endtask

  task automatic apply_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (!(o[1] && b == '0)) begin
      r = model_res(o, a, b);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++; $display("FAIL reset_flags: busy=%b done=%b div_zero=%b expected 0 0 0", busy, done, div_zero); end
    checks++; if (hi !== '0 || lo !== '0) begin
      failures++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0 0", hi, lo); end
    resetn = 1'b1;
    start = 1'b1; op = 2'b01; in0 = 32'd2; in1 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin
      failures++; $display("FAIL reset_first_start: busy=%b expected 1", busy); end
    while (!done) @(negedge clk);
    apply_model(2'b01, 32'd2, 32'd3);
  endtask

  task automatic test_vectors();
    logic [1:0]  vo [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] va [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] vb [5] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000002, 32'd7, 32'hFFFFFFFF};
    logic [31:0] eh [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h2, 32'h0};
    logic [31:0] el [5] = '{32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32'hE, 32'h80000000};
    int lat, bc; logic dz;
    for (int i = 0; i < 5; i++) begin
      do_op(vo[i], va[i], vb[i], lat, bc, dz);
      checks++; if (lat !== 34 || bc !== 33 || dz !== 1'b0) begin
        failures++; $display("FAIL vec%0d_timing: lat=%0d busy=%0d dz=%b expected 34 33 0", i, lat, bc, dz); end
      checks++; if (hi !== eh[i] || lo !== el[i]) begin
        failures++; $display("FAIL vec%0d_result: hi=%h lo=%h expected %h %h", i, hi, lo, eh[i], el[i]); end
      m_hi = eh[i]; m_lo = el[i];
    end
    // Divide by zero with preloaded HI/LO
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 32'h12345678; m_lo = 32'h12345678;
    do_op(2'b11, 32'd55, 32'd0, lat, bc, dz);
    checks++; if (lat !== 2 || dz !== 1'b1) begin
      failures++; $display("FAIL divzero_timing: lat=%0d dz=%b expected 2 1", lat, dz); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'h12345678) begin
      failures++; $display("FAIL divzero_hilo: hi=%h lo=%h expected 12345678 12345678", hi, lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin
      failures++; $display("FAIL divzero_pulse: done=%b div_zero=%b expected 0 0", done, div_zero); end
  endtask

  task automatic test_random();
    int lat, bc, elat; logic dz;
    logic [1:0] o; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'd1;
        3: a = 32'($urandom_range(0, 20));
        4: b = 32'($urandom_range(1, 9)) | (b & 32'h80000000);
        default: ;
      endcase
      do_op(o, a, b, lat, bc, dz);
      apply_model(o, a, b);
      elat = (o[1] && b == '0) ? 2 : 34;
      checks++; if (lat !== elat || dz !== (o[1] && b == '0)) begin
        failures++; $display("FAIL rand%0d_timing: op=%0d lat=%0d dz=%b expected lat %0d", i, o, lat, dz, elat); end
      checks++; if (hi !== m_hi || lo !== m_lo) begin
        failures++; $display("FAIL rand%0d_result: op=%0d a=%h b=%h hi=%h lo=%h expected %h %h", i, o, a, b, hi, lo, m_hi, m_lo); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin
        failures++; $display("FAIL rand%0d_done_width: done=%b expected 0", i, done); end
    end
  endtask

  task automatic test_cancel();
    int extra_done = 0;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 32'hCAFEF00D; m_lo = 32'hCAFEF00D;
    start = 1'b1; op = 2'b01; in0 = $urandom; in1 = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL cancel_busy: busy=%b expected 0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (done || div_zero) extra_done++;
      @(negedge clk);
    end
    checks++; if (extra_done !== 0 || hi !== m_hi || lo !== m_lo) begin
      failures++; $display("FAIL cancel_hilo: pulses=%0d hi=%h lo=%h expected 0 %h %h", extra_done, hi, lo, m_hi, m_lo); end
    // Same point in the operation, but via reset
    start = 1'b1; op = 2'b01; in0 = $urandom; in1 = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_hi = '0; m_lo = '0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++; $display("FAIL midop_reset: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo); end
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) extra_done++;
      @(negedge clk);
    end
    checks++; if (extra_done !== 0) begin
      failures++; $display("FAIL midop_reset_idle: active_cycles=%0d expected 0", extra_done); end
    // cancel in IDLE blocks a simultaneous start
    start = 1'b1; cancel = 1'b1; op = 2'b00; in0 = 32'd5; in1 = 32'd6;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL cancel_idle_start: busy=%b expected 0", busy); end
  endtask

  task automatic test_hilo_write();
    int lat;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hA5A5A5A5; start = 1'b1; op = 2'b01; in0 = 32'd3; in1 = 32'd5;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0; lat = 1;
    m_hi = 32'hA5A5A5A5;
    checks++; if (hi !== 32'hA5A5A5A5 || busy !== 1'b1) begin
      failures++; $display("FAIL write_with_start: hi=%h busy=%b expected a5a5a5a5 1", hi, busy); end
    while (!done && lat < 200) begin
      if (lat == 5) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF; end
      if (lat == 6) begin
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== m_hi || lo !== m_lo) begin
          failures++; $display("FAIL write_while_busy: hi=%h lo=%h expected %h %h", hi, lo, m_hi, m_lo); end
      end
      @(negedge clk);
      lat++;
    end
    apply_model(2'b01, 32'd3, 32'd5);
    checks++; if (lat !== 34 || hi !== m_hi || lo !== m_lo) begin
      failures++; $display("FAIL write_then_result: lat=%0d hi=%h lo=%h expected 34 %h %h", lat, hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_back_to_back();
    int lat = 1, first = -1, second = -1;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b1; op = 2'b00; in0 = a; in1 = b;
    @(negedge clk);
    while (second < 0 && lat < 200) begin
      if (done) begin
        if (first < 0) first = lat;
        else second = lat;
      end
      if (second < 0) begin
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    apply_model(2'b00, a, b);
    checks++; if (first !== 34 || second !== 68) begin
      failures++; $display("FAIL back_to_back_timing: first=%0d second=%0d expected 34 68", first, second); end
    checks++; if (hi !== m_hi || lo !== m_lo) begin
      failures++; $display("FAIL back_to_back_result: hi=%h lo=%h expected %h %h", hi, lo, m_hi, m_lo); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_cancel();
    test_hilo_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width; legal values are even and >= 8.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port in0  input  WIDTH  multiplicand / dividend (reg[rs]).
REQ-007 SHALL have port in1  input  WIDTH  multiplier / divisor (reg[rt]).
REQ-008 SHALL have port cancel  input  1  abort the in-flight operation (exception flush).
REQ-009 SHALL have port hi_we  input  1  direct HI write (MTHI).
REQ-010 SHALL have port lo_we  input  1  direct LO write (MTLO).
REQ-011 SHALL have port wdata  input  WIDTH  data for hi_we/lo_we.
REQ-012 SHALL have port busy  output  1  operation in flight; the pipeline stalls on it.
REQ-013 SHALL have port done  output  1  one-cycle pulse when HI/LO take a result.
REQ-014 SHALL have port div_zero  output  1  one-cycle pulse, divisor was zero.
REQ-015 SHALL have port hi  output  WIDTH  HI register.
REQ-016 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, FIX; busy SHALL be high in CALC and FIX only.
REQ-018 In IDLE, start=1 with cancel=0 SHALL latch operands and op and move to CALC; start SHALL be ignored in CALC and FIX.
REQ-019 Signed ops (MULT, DIV) SHALL compute on operand magnitudes and restore sign in FIX; unsigned ops SHALL skip sign correction.
REQ-020 CALC SHALL perform exactly one radix-2 iteration per cycle (shift-add for multiply, restoring shift-subtract for divide) for WIDTH cycles, counted by an internal down-counter of clog2(WIDTH)+1 bits.
REQ-021 FIX SHALL last one cycle, write the result to {hi,lo}, pulse done and return to IDLE; done SHALL therefore rise on the WIDTH+2nd rising edge after the edge that accepts start.
REQ-022 Multiply result SHALL be the full 2*WIDTH-bit product, hi = upper half, lo = lower half; MULT sign SHALL be negative iff operand signs differ.
REQ-023 Divide SHALL put quotient in lo and remainder in hi; quotient negative iff operand signs differ; remainder SHALL take the dividend's sign.
REQ-024 DIV of most-negative value by -1 SHALL give lo = most-negative value, hi = 0, no flag.
REQ-025 DIV/DIVU with in1 = 0 SHALL skip CALC: go to FIX, pulse done and div_zero together on the 2nd edge after start, and leave hi/lo unchanged.
REQ-026 cancel=1 in CALC or FIX SHALL return to IDLE on that edge with no done, no div_zero and hi/lo unchanged; cancel in IDLE SHALL block a simultaneous start.
REQ-027 hi_we/lo_we SHALL update hi/lo with wdata on the edge only while in IDLE; they SHALL be ignored while busy; if asserted with start in IDLE, the write SHALL apply and start SHALL still be accepted.
REQ-028 done and div_zero SHALL never be high outside the single FIX-exit cycle.

Reset
REQ-029 resetn=0 at a rising edge SHALL force IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0, regardless of state, including mid-operation.
REQ-030 After resetn returns high, the first start SHALL be accepted on the next edge.

Verification (WIDTH=32)
REQ-031 MULT in0=FFFFFFFF, in1=00000002 -> done on 34th edge, hi=FFFFFFFF, lo=FFFFFFFE; busy high for 33 cycles.
REQ-032 MULTU in0=FFFFFFFF, in1=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-033 DIV in0=FFFFFFF9 (-7), in1=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU in0=100, in1=7 -> lo=0000000E, hi=00000002.
REQ-034 DIV in0=80000000, in1=FFFFFFFF -> lo=80000000, hi=00000000; DIVU in1=0 with hi=lo=12345678 preloaded -> done+div_zero on 2nd edge, hi/lo still 12345678.
REQ-035 Start MULTU, assert cancel at iteration 10 -> busy low next cycle, no done, hi/lo unchanged; repeat with resetn=0 instead -> hi=lo=0, IDLE.
REQ-036 hi_we during CALC -> hi unchanged; hi_we=1, wdata=A5A5A5A5 with start in IDLE -> hi=A5A5A5A5 next edge, later overwritten by the result at done.
